instr_feed_slave: RTL and testbench
===================================

# instr_feed_slave

Instruction-side memory responder sitting directly upstream of `riscv_core`. It drives the core's `instr_gnt_i`, `instr_rvalid_i` and `instr_rdata_i` pins, and answers `instr_req_o` / `instr_addr_o`. Instruction words are loaded from the test side through a push port into an internal FIFO. It replaces ad-hoc per-instruction pin wiggling with a cycle-accurate, protocol-correct fetch channel.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, minimum 2.
- `ADDR_W`, 32: instruction address width.

Ports:
- `clk_i`  in  1  core clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `push_valid_i`  in  1  test side presents an instruction word.
- `push_instr_i`  in  32  instruction word.
- `push_ready_o`  out  1  FIFO can accept a word; equals not full.
- `flush_i`  in  1  discard all queued words.
- `instr_req_i`  in  1  from core `instr_req_o`.
- `instr_addr_i`  in  ADDR_W  from core `instr_addr_o`.
- `instr_gnt_o`  out  1  to core `instr_gnt_i`.
- `instr_rvalid_o`  out  1  to core `instr_rvalid_i`.
- `instr_rdata_o`  out  32  to core `instr_rdata_i`.
- `rsp_addr_o`  out  ADDR_W  address belonging to the current response.
- `level_o`  out  $clog2(DEPTH+1)  number of queued words.
- `served_cnt_o`  out  32  total responses delivered; wraps modulo 2^32.

## Operation
- Push: a word is written when `push_valid_i` and `push_ready_o` are both high and `flush_i` is low.
- Grant:
  - `instr_gnt_o` is combinational: `instr_req_i & !empty & !flush_i & rst_ni`.
  - A grant pops the FIFO head into the response register.
- Response register:
  - The cycle after a grant: `instr_rvalid_o`=1, `instr_rdata_o`=popped word, `rsp_addr_o`=address latched at grant.
  - Otherwise `instr_rvalid_o`=0; `instr_rdata_o` and `rsp_addr_o` hold their last values.
- Back-to-back grants are legal, giving one response per cycle. Responses are in order; there is no reordering.
- Full FIFO with a grant in the same cycle: `push_ready_o` stays 0 that cycle. There is no pop-to-push bypass.
- Empty FIFO with a push in the same cycle: no bypass. The word becomes grantable on the next cycle.
- Flush:
  - `level_o` goes to 0 on the next edge.
  - A push or grant in the flush cycle is suppressed.
  - A response already registered from the previous cycle still completes.
- `served_cnt_o` increments on every cycle in which `instr_rvalid_o` is 1.
- Reset mid-operation: FIFO cleared, and any pending response is dropped with no rvalid after reset is released.

## Timing
- Reset values: `push_ready_o`=1, `instr_gnt_o`=0, `instr_rvalid_o`=0, `instr_rdata_o`=0, `rsp_addr_o`=0, `level_o`=0, `served_cnt_o`=0.
- Latencies:
  - req to gnt: 0 cycles.
  - gnt to rvalid: exactly 1 cycle.
  - push to grantable: 1 cycle.
- Throughput: 1 instruction per cycle while the FIFO is non-empty.
- Two-state control only. IDLE means no response pending; RESP means `instr_rvalid_o` is high.
  - IDLE to RESP on a grant.
  - RESP to RESP on a grant.
  - RESP to IDLE with no grant.
- Flush does not change the state on its own.

## Configuration
- `INSTR_FEED_NOP_FILL_EN` defined:
  - When the FIFO is empty, the block still grants every request and returns `NOP_INSTR` (32'h00000013).
  - A NOP response counts in `served_cnt_o`. `level_o` stays 0.
- Not defined: `instr_gnt_o` stays low while the FIFO is empty, and the core stalls.

## Structure
- Package `instr_feed_pkg` holds:
  - the constant `NOP_INSTR` = 32'h00000013;
  - the typedef `instr_rsp_t` (`rdata` [31:0], `addr` [ADDR_W-1:0]);
  - the state enum `feed_state_e` {IDLE, RESP}.
- One sub-module, `instr_feed_fifo`: a synchronous FIFO with push, pop, flush, full, empty and level. The top level holds the grant logic, the response register and the counter.

## Test plan
- Reset, then push 32'h000Fa103 and 32'h000Fa183 while `instr_req_i`=1 from the start:
  - gnt on cycles 1 and 2 after the first push;
  - rvalid with rdata 32'h000Fa103, then 32'h000Fa183;
  - `served_cnt_o`=2.
- Fill 8 words, then try a push: `push_ready_o`=0 and `level_o`=8. One grant gives `level_o`=7 and `push_ready_o`=1 on the next cycle.
- Empty FIFO with `instr_req_i`=1:
  - with the macro: gnt=1 and rdata 32'h00000013 on the next cycle;
  - without it: gnt=0 until the next push.
- Queue 3 words and assert `flush_i` together with `instr_req_i`: no gnt that cycle, and `level_o`=0 next cycle. The previously registered response still completes.
- Grant at `instr_addr_i`=32'h00000080, then drop `rst_ni` before the next edge: no rvalid after reset release, and all outputs are at their reset values.
- Preload `served_cnt_o` near wrap by forcing it to 32'hFFFFFFFF, then deliver one response: `served_cnt_o`=0.

Source files
------------

// File: rtl/instr_feed_pkg.sv
// Shared types and constants for the instruction feed responder.
package instr_feed_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h00000013;
    localparam int          INSTR_ADDR_W = 32;

    typedef struct packed {
        logic [31:0]             rdata;
        logic [INSTR_ADDR_W-1:0] addr;
    } instr_rsp_t;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } feed_state_e;

endpackage

// File: rtl/instr_feed_fifo.sv
// Synchronous FIFO holding queued instruction words; push/pop are pre-qualified by the caller.
module instr_feed_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [W-1:0]               head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == LW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;

endmodule

// File: rtl/instr_feed_slave.sv
// Instruction-side responder for riscv_core: FIFO-fed grant/rvalid channel.
// Optional INSTR_FEED_NOP_FILL_EN: grant from an empty FIFO and answer with NOP_INSTR.
module instr_feed_slave
    import instr_feed_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_valid_i,
    input  logic [31:0]                push_instr_i,
    output logic                       push_ready_o,
    input  logic                       flush_i,
    input  logic                       instr_req_i,
    input  logic [ADDR_W-1:0]          instr_addr_i,
    output logic                       instr_gnt_o,
    output logic                       instr_rvalid_o,
    output logic [31:0]                instr_rdata_o,
    output logic [ADDR_W-1:0]          rsp_addr_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic [31:0]                served_cnt_o,
    output feed_state_e                state_o
);

    localparam int LW = $clog2(DEPTH+1);

    logic          fifo_full, fifo_empty;
    logic          push_en, pop_en;
    logic [31:0]   head_word, rsp_word;
    logic [LW-1:0] fifo_level;

    feed_state_e state_q, state_d;
    instr_rsp_t  rsp_q, rsp_d;
    logic [31:0] served_q, served_d;

    // Handshakes: a push transfers when push_valid_i & push_ready_o are high on an
    // edge (flush cancels it); a fetch is accepted when instr_req_i & instr_gnt_o are
    // high on an edge, and its data appears with instr_rvalid_o exactly one cycle later.
    assign push_ready_o = !fifo_full;
    assign push_en      = push_valid_i & !fifo_full & !flush_i;

`ifdef INSTR_FEED_NOP_FILL_EN
    assign instr_gnt_o = instr_req_i & !flush_i & rst_ni;
    assign pop_en      = instr_gnt_o & !fifo_empty;
    assign rsp_word    = fifo_empty ? NOP_INSTR : head_word;
`else
    assign instr_gnt_o = instr_req_i & !fifo_empty & !flush_i & rst_ni;
    assign pop_en      = instr_gnt_o;
    assign rsp_word    = head_word;
`endif

    instr_feed_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_en),
        .data_i  (push_instr_i),
        .pop_i   (pop_en),
        .flush_i (flush_i),
        .head_o  (head_word),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        state_d  = instr_gnt_o ? RESP : IDLE;
        rsp_d    = rsp_q;
        served_d = served_q + {31'b0, (state_q == RESP)};
        if (instr_gnt_o) begin
            rsp_d.rdata = rsp_word;
            rsp_d.addr  = INSTR_ADDR_W'(instr_addr_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rsp_q    <= '0;
            served_q <= '0;
        end else begin
            state_q  <= state_d;
            rsp_q    <= rsp_d;
            served_q <= served_d;
        end
    end

    assign instr_rvalid_o = (state_q == RESP);
    assign instr_rdata_o  = rsp_q.rdata;
    assign rsp_addr_o     = rsp_q.addr[ADDR_W-1:0];
    assign level_o        = fifo_level;
    assign served_cnt_o   = served_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_instr_feed_slave.sv
// Directed self-checking bench for instr_feed_slave (honours INSTR_FEED_NOP_FILL_EN).
module tb_instr_feed_slave;
    import instr_feed_pkg::*;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 32;
    localparam int LW     = $clog2(DEPTH+1);

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              push_valid_i;
    logic [31:0]       push_instr_i;
    logic              push_ready_o;
    logic              flush_i;
    logic              instr_req_i;
    logic [ADDR_W-1:0] instr_addr_i;
    logic              instr_gnt_o;
    logic              instr_rvalid_o;
    logic [31:0]       instr_rdata_o;
    logic [ADDR_W-1:0] rsp_addr_o;
    logic [LW-1:0]     level_o;
    logic [31:0]       served_cnt_o;
    feed_state_e       state_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_word;

    // clock / reset
    always #5 clk_i = ~clk_i;

    instr_feed_slave #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .push_valid_i   (push_valid_i),
        .push_instr_i   (push_instr_i),
        .push_ready_o   (push_ready_o),
        .flush_i        (flush_i),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .rsp_addr_o     (rsp_addr_o),
        .level_o        (level_o),
        .served_cnt_o   (served_cnt_o),
        .state_o        (state_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_push(input logic v, input logic [31:0] w);
        push_valid_i = v;
        push_instr_i = w;
    endtask

    task automatic drive_req(input logic r, input logic [ADDR_W-1:0] a);
        instr_req_i  = r;
        instr_addr_i = a;
    endtask

    task automatic expect_rsp(input string tag, input logic [ADDR_W-1:0] a);
        exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check_eq({tag, "_rvalid"}, 32'(instr_rvalid_o), 32'd1);
        check_eq({tag, "_rdata"}, instr_rdata_o, exp_word);
        check_eq({tag, "_addr"}, rsp_addr_o, a);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_push_ready"}, 32'(push_ready_o), 32'd1);
        check_eq({tag, "_gnt"}, 32'(instr_gnt_o), 32'd0);
        check_eq({tag, "_rvalid"}, 32'(instr_rvalid_o), 32'd0);
        check_eq({tag, "_rdata"}, instr_rdata_o, 32'd0);
        check_eq({tag, "_addr"}, rsp_addr_o, 32'd0);
        check_eq({tag, "_level"}, 32'(level_o), 32'd0);
        check_eq({tag, "_served"}, served_cnt_o, 32'd0);
        check_eq({tag, "_state"}, 32'(state_o), 32'(IDLE));
    endtask

    initial begin
        rst_ni = 1'b0;
        flush_i = 1'b0;
        drive_push(1'b0, 32'h0);
        drive_req(1'b1, 32'h0);
        #3;
        check_reset_outputs("reset");
        tick();
        rst_ni = 1'b1;
        drive_req(1'b0, 32'h0);
        tick();

        // two back-to-back fetches
`ifdef INSTR_FEED_NOP_FILL_EN
        drive_req(1'b0, 32'h100);
`else
        drive_req(1'b1, 32'h100);
`endif
        drive_push(1'b1, 32'h000Fa103);
        exp_q.push_back(32'h000Fa103);
        #1;
        check_eq("t1_gnt_before_push", 32'(instr_gnt_o), 32'd0);
        tick();
        drive_req(1'b1, 32'h100);
        drive_push(1'b1, 32'h000Fa183);
        exp_q.push_back(32'h000Fa183);
        #1;
        check_eq("t1_gnt_cycle1", 32'(instr_gnt_o), 32'd1);
        check_eq("t1_level1", 32'(level_o), 32'd1);
        tick();
        drive_push(1'b0, 32'h0);
        drive_req(1'b1, 32'h104);
        #1;
        expect_rsp("t1_rsp0", 32'h100);
        check_eq("t1_gnt_cycle2", 32'(instr_gnt_o), 32'd1);
        check_eq("t1_state_resp", 32'(state_o), 32'(RESP));
        tick();
        drive_req(1'b0, 32'h0);
        #1;
        expect_rsp("t1_rsp1", 32'h104);
        check_eq("t1_level_empty", 32'(level_o), 32'd0);
        tick();
        check_eq("t1_rvalid_low", 32'(instr_rvalid_o), 32'd0);
        check_eq("t1_rdata_hold", instr_rdata_o, 32'h000Fa183);
        check_eq("t1_served", served_cnt_o, 32'd2);
        check_eq("t1_state_idle", 32'(state_o), 32'(IDLE));

        // fill to full, grant while full, then drain
        for (int i = 0; i < DEPTH; i++) begin
            drive_push(1'b1, 32'h1000_0000 + 32'(i));
            exp_q.push_back(32'h1000_0000 + 32'(i));
            tick();
        end
        check_eq("t2_level_full", 32'(level_o), 32'd8);
        drive_push(1'b1, 32'hBAD0_0001);
        drive_req(1'b1, 32'h200);
        #1;
        check_eq("t2_ready_full", 32'(push_ready_o), 32'd0);
        check_eq("t2_gnt_full", 32'(instr_gnt_o), 32'd1);
        tick();
        drive_push(1'b0, 32'h0);
        drive_req(1'b0, 32'h0);
        #1;
        check_eq("t2_level7", 32'(level_o), 32'd7);
        check_eq("t2_ready_after", 32'(push_ready_o), 32'd1);
        expect_rsp("t2_rsp_first", 32'h200);
        drive_req(1'b1, 32'h204);
        for (int i = 0; i < DEPTH - 1; i++) begin
            tick();
            expect_rsp("t2_drain", 32'h204);
        end
        drive_req(1'b0, 32'h0);
        check_eq("t2_level_drained", 32'(level_o), 32'd0);
        tick();

        // empty FIFO with a pending request
        drive_req(1'b1, 32'h300);
        #1;
`ifdef INSTR_FEED_NOP_FILL_EN
        check_eq("t3_gnt_nop", 32'(instr_gnt_o), 32'd1);
        exp_q.push_back(NOP_INSTR);
        tick();
        drive_req(1'b0, 32'h0);
        #1;
        expect_rsp("t3_nop", 32'h300);
        check_eq("t3_level_nop", 32'(level_o), 32'd0);
        tick();
`else
        check_eq("t3_gnt_empty", 32'(instr_gnt_o), 32'd0);
        tick();
        check_eq("t3_gnt_still_empty", 32'(instr_gnt_o), 32'd0);
        check_eq("t3_no_rvalid", 32'(instr_rvalid_o), 32'd0);
        drive_push(1'b1, 32'hC0DE_0001);
        exp_q.push_back(32'hC0DE_0001);
        #1;
        check_eq("t3_no_bypass", 32'(instr_gnt_o), 32'd0);
        tick();
        drive_push(1'b0, 32'h0);
        #1;
        check_eq("t3_gnt_after_push", 32'(instr_gnt_o), 32'd1);
        tick();
        drive_req(1'b0, 32'h0);
        #1;
        expect_rsp("t3_rsp", 32'h300);
        tick();
`endif

        // flush with a registered response in flight
        for (int i = 0; i < 3; i++) begin
            drive_push(1'b1, 32'hD000_0000 + 32'(i));
            exp_q.push_back(32'hD000_0000 + 32'(i));
            tick();
        end
        drive_push(1'b0, 32'h0);
        drive_req(1'b1, 32'h400);
        tick();
        flush_i = 1'b1;
        drive_push(1'b1, 32'hBAD0_0002);
        drive_req(1'b1, 32'h404);
        #1;
        check_eq("t4_gnt_flush", 32'(instr_gnt_o), 32'd0);
        expect_rsp("t4_inflight", 32'h400);
        tick();
        flush_i = 1'b0;
        drive_push(1'b0, 32'h0);
        drive_req(1'b0, 32'h0);
        exp_q.delete();
        #1;
        check_eq("t4_level_flushed", 32'(level_o), 32'd0);
        check_eq("t4_rvalid_low", 32'(instr_rvalid_o), 32'd0);
        tick();

        // reset between a grant and its response edge
        drive_push(1'b1, 32'hF000_0001);
        tick();
        drive_push(1'b0, 32'h0);
        drive_req(1'b1, 32'h80);
        #1;
        check_eq("t5_gnt", 32'(instr_gnt_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check_eq("t5_gnt_in_reset", 32'(instr_gnt_o), 32'd0);
        tick();
        drive_req(1'b0, 32'h0);
        rst_ni = 1'b1;
        #1;
        check_reset_outputs("t5_after_reset");
        tick();
        check_eq("t5_no_rvalid", 32'(instr_rvalid_o), 32'd0);

        // served counter wraps
        drive_push(1'b1, 32'hE000_0001);
        exp_q.push_back(32'hE000_0001);
        tick();
        drive_push(1'b0, 32'h0);
        drive_req(1'b1, 32'h500);
        force dut.served_q = 32'hFFFF_FFFF;
        tick();
        drive_req(1'b0, 32'h0);
        release dut.served_q;
        #1;
        expect_rsp("t6_rsp", 32'h500);
        check_eq("t6_served_preload", served_cnt_o, 32'hFFFF_FFFF);
        tick();
        check_eq("t6_served_wrap", served_cnt_o, 32'd0);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
